ws2812_input: RTL and testbench

//  Receiver for the WS2812 single-wire LED protocol, the counterpart of our ws2812_output transmitter.

---
 rtl/ws2812_input.sv | 147 ++++++++++++++
 tb/tb_ws2812_input.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_input.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ws2812_input: WS2812 single-wire receiver. It decodes MSB-first bytes and   |
// | flags end-of-frame. The optional WS2812_INPUT_PASSTHRU_EN forwards the line |
// | once CAPTURE_BYTES bytes have been decoded. Rev 1.0                         |
// +----------------------------------------------------------------------------+
module ws2812_input #(
   parameter int INPUT_CLOCK   = 12_000_000,
   parameter int CAPTURE_BYTES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_end,
   output logic       error,
   output logic       out
);
   localparam int TIME_MIN_HI     = $rtoi(200e-9 * INPUT_CLOCK);
   localparam int TIME_BIT_THRESH = $rtoi(575e-9 * INPUT_CLOCK);
   localparam int TIME_MAX_HI     = $rtoi(2e-6 * INPUT_CLOCK);
   localparam int TIME_RESET      = $rtoi(50e-6 * INPUT_CLOCK);
   localparam int CW              = $clog2(TIME_RESET + 1);
   localparam int BCW             = $clog2(CAPTURE_BYTES + 1);

   localparam logic [CW-1:0]  C_MIN_HI    = CW'(TIME_MIN_HI);
   localparam logic [CW-1:0]  C_THRESH    = CW'(TIME_BIT_THRESH);
   localparam logic [CW-1:0]  C_MAX_HI    = CW'(TIME_MAX_HI);
   localparam logic [CW-1:0]  C_MAX_HI_M1 = CW'(TIME_MAX_HI - 1);
   localparam logic [CW-1:0]  C_RESET     = CW'(TIME_RESET);
   localparam logic [CW-1:0]  C_RESET_M1  = CW'(TIME_RESET - 1);
   localparam logic [BCW-1:0] C_CAP       = BCW'(CAPTURE_BYTES);

   typedef enum logic [1:0] {S_SYNC = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2} state_t;

   state_t         r_state;
   logic [1:0]     r_sync;
   logic [CW-1:0]  r_hcnt;
   logic [CW-1:0]  r_lcnt;
   logic [7:0]     r_shift;
   logic [2:0]     r_bitcnt;
   logic [BCW-1:0] r_bytecnt;
   logic           r_active;
   logic [7:0]     r_data;
   logic           r_valid;
   logic           r_fend;
   logic           r_error;

   logic           w_s_in;
   logic           w_passthru;
   logic [7:0]     w_shift_nxt;

   assign w_s_in      = r_sync[1];
   assign w_shift_nxt = {r_shift[6:0], (r_hcnt >= C_THRESH)};

`ifdef WS2812_INPUT_PASSTHRU_EN
   assign w_passthru = (r_bytecnt == C_CAP);
   assign out        = w_passthru & w_s_in;
`else
   assign w_passthru = 1'b0;
   assign out        = 1'b0;
`endif

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign frame_end  = r_fend;
   assign error      = r_error;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_SYNC;
         r_sync    <= 2'b00;
         r_hcnt    <= '0;
         r_lcnt    <= '0;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_bytecnt <= '0;
         r_active  <= 1'b0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_fend    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], in};
         r_valid <= 1'b0;
         r_fend  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            S_SYNC: begin
               // Decoding resumes only after a full reset-length low period
               if (w_s_in) begin
                  r_lcnt <= '0;
               end else begin
                  if (r_lcnt != C_RESET) r_lcnt <= r_lcnt + CW'(1);
                  if (r_lcnt == C_RESET_M1) r_state <= S_LOW;
               end
            end
            S_LOW: begin
               if (w_s_in) begin
                  r_state <= S_HIGH;
                  r_hcnt  <= CW'(1);
               end else begin
                  if (r_lcnt != C_RESET) r_lcnt <= r_lcnt + CW'(1);
                  if (r_lcnt == C_RESET_M1 && r_active) begin
                     r_fend    <= 1'b1;
                     r_active  <= 1'b0;
                     r_bitcnt  <= '0;
                     r_bytecnt <= '0;
                  end
               end
            end
            S_HIGH: begin
               if (!w_s_in) begin
                  r_state <= S_LOW;
                  r_lcnt  <= CW'(1);
                  if (r_hcnt < C_MIN_HI) begin
                     r_error  <= 1'b1;
                     r_bitcnt <= '0;
                  end else begin
                     r_active <= 1'b1;
                     r_shift  <= w_shift_nxt;
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7 && !w_passthru) begin
                        r_data  <= w_shift_nxt;
                        r_valid <= 1'b1;
                        if (r_bytecnt != C_CAP) r_bytecnt <= r_bytecnt + BCW'(1);
                     end
                  end
               end else begin
                  if (r_hcnt != C_MAX_HI) r_hcnt <= r_hcnt + CW'(1);
                  if (r_hcnt == C_MAX_HI_M1) begin
                     r_error   <= 1'b1;
                     r_bitcnt  <= '0;
                     r_bytecnt <= '0;
                     r_active  <= 1'b0;
                     r_lcnt    <= '0;
                     r_state   <= S_SYNC;
                  end
               end
            end
            default: r_state <= S_SYNC;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ws2812_input.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ws2812_input: directed vectors and corner sequences for ws2812_input.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ws2812_input;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in  = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_end;
   logic       error;
   logic       out;

   ws2812_input #(.INPUT_CLOCK(12_000_000), .CAPTURE_BYTES(3)) dut (
      .clk(clk), .rst(rst), .in(in), .data_out(data_out), .data_valid(data_valid),
      .frame_end(frame_end), .error(error), .out(out)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_dv, n_fe, n_err, n_outhi;
   int         last_dv_cyc, last_fe_cyc, fall_cyc;
   logic [7:0] dq[$];
   int         errors = 0;
   int         checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (data_valid) begin
            dq.push_back(data_out);
            n_dv++;
            last_dv_cyc = cyc;
         end
         if (frame_end) begin
            n_fe++;
            last_fe_cyc = cyc;
         end
         if (error) n_err++;
         if (out) n_outhi++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_dv = 0; n_fe = 0; n_err = 0; n_outhi = 0;
      dq.delete();
   endtask

   task automatic send_bit(input logic b);
      in = 1'b1;
      tick(b ? 9 : 4);
      in = 1'b0;
      fall_cyc = cyc;
      tick(b ? 8 : 13);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " data_out"}, {24'd0, data_out}, 32'd0);
      check({tag, " data_valid"}, {31'd0, data_valid}, 32'd0);
      check({tag, " frame_end"}, {31'd0, frame_end}, 32'd0);
      check({tag, " error"}, {31'd0, error}, 32'd0);
      check({tag, " out"}, {31'd0, out}, 32'd0);
   endtask

   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_data;
      int         exp_dv;
      int         exp_fe;
      int         exp_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'h00, 8'h00, 1, 1, 0};
      vecs[1] = '{8'hFF, 8'hFF, 1, 1, 0};
      vecs[2] = '{8'h3C, 8'h3C, 1, 1, 0};
      vecs[3] = '{8'h81, 8'h81, 1, 1, 0};
      vecs[4] = '{8'h5A, 8'h5A, 1, 1, 0};
      vecs[5] = '{8'h01, 8'h01, 1, 1, 0};

      tick(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      clear_counts();
      tick(700);

      // Single byte with latency checks
      send_byte(8'hA5);
      tick(720 - 8);
      check("t1 dv count", n_dv, 1);
      check("t1 data", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, 32'hA5);
      check("t1 fe count", n_fe, 1);
      check("t1 err count", n_err, 0);
      check("t1 dv latency", last_dv_cyc - fall_cyc, 3);
      check("t1 fe latency", last_fe_cyc - fall_cyc, 602);
      check("t1 data held", {24'd0, data_out}, 32'hA5);

      for (int i = 0; i < 6; i++) begin
         clear_counts();
         send_byte(vecs[i].din);
         tick(720);
         check($sformatf("vec%0d dv", i), n_dv, vecs[i].exp_dv);
         check($sformatf("vec%0d data", i),
               (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, {24'd0, vecs[i].exp_data});
         check($sformatf("vec%0d fe", i), n_fe, vecs[i].exp_fe);
         check($sformatf("vec%0d err", i), n_err, vecs[i].exp_err);
      end

      // Three back-to-back bytes, one frame
      clear_counts();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
      tick(720);
      check("t2 dv count", n_dv, 3);
      check("t2 byte0", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, 32'h00);
      check("t2 byte1", (dq.size() > 1) ? {24'd0, dq[1]} : 32'hFFFF_FFFF, 32'hFF);
      check("t2 byte2", (dq.size() > 2) ? {24'd0, dq[2]} : 32'hFFFF_FFFF, 32'h3C);
      check("t2 fe count", n_fe, 1);
      check("t2 err count", n_err, 0);

      // Runt pulse mid-byte drops the partial byte
      clear_counts();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      in = 1'b1; tick(1); in = 1'b0; tick(13);
      send_byte(8'h81);
      tick(720);
      check("t3 err count", n_err, 1);
      check("t3 dv count", n_dv, 1);
      check("t3 data", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, 32'h81);
      check("t3 fe count", n_fe, 1);

      // Overlong pulse forces resync
      clear_counts();
      in = 1'b1; tick(30); in = 1'b0;
      tick(100);
      send_byte(8'h55);
      tick(700);
      send_byte(8'hC3);
      tick(720);
      check("t4 err count", n_err, 1);
      check("t4 dv count", n_dv, 1);
      check("t4 data", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, 32'hC3);
      check("t4 fe count", n_fe, 1);

      // Reset in the middle of a byte
      clear_counts();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      rst = 1'b0;
      tick(1);
      check_reset_outputs("t5 reset");
      rst = 1'b1;
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      send_byte(8'h66);
      tick(700);
      send_byte(8'h99);
      tick(720);
      check("t5 dv count", n_dv, 1);
      check("t5 data", (dq.size() > 0) ? {24'd0, dq[0]} : 32'hFFFF_FFFF, 32'h99);
      check("t5 fe count", n_fe, 1);
      check("t5 err count", n_err, 0);

`ifdef WS2812_INPUT_PASSTHRU_EN
      clear_counts();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      tick(720);
      check("t6 dv count", n_dv, 3);
      check("t6 byte2", (dq.size() > 2) ? {24'd0, dq[2]} : 32'hFFFF_FFFF, 32'h33);
      check("t6 out high cycles", n_outhi, 42);
      check("t6 fe count", n_fe, 1);
      check("t6 out after frame", {31'd0, out}, 32'd0);
`else
      check("out never high", n_outhi, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
